// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one async-FIFO write port (winc/wdata) among NREQ requesters.
// Latency : one ARB cycle from req_valid to grant; req_ready and winc are combinational within a burst.
// Backpressure: a registered wfull stalls the burst without releasing it.
//               With AF_STOP=1, almost_full blocks new grants only.
//
// Ports:
//   wclk, wrst            write-domain clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; a transfer is valid & ready
//   req_data              packed data, requester i at [i*DATASIZE +: DATASIZE]
//   req_last              (FIFO_WR_ARB_PKT_LOCK_EN only) marks the final beat of a packet
//   winc/wdata            FIFO write port; wdata is zero when winc is low
//   wfull/almost_full     registered FIFO status flags
//   grant/grant_id/busy   registered one-hot grant, its index, and burst-in-progress flag
//
// Optional feature macro: FIFO_WR_ARB_PKT_LOCK_EN
//   When defined, a grant is held until a transfer carrying req_last. MAX_BURST and the
//   valid-low release rule do not apply in this mode.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATASIZE  = 8,
  parameter int MAX_BURST = 8,
  parameter int AF_STOP   = 1
) (
  input  logic                                        wclk,
  input  logic                                        wrst,
  input  logic [NREQ-1:0]                             req_valid,
  input  logic [NREQ*DATASIZE-1:0]                    req_data,
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  input  logic [NREQ-1:0]                             req_last,
`endif
  output logic [NREQ-1:0]                             req_ready,
  output logic                                        winc,
  output logic [DATASIZE-1:0]                         wdata,
  input  logic                                        wfull,
  input  logic                                        almost_full,
  output logic [NREQ-1:0]                             grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  grant_id,
  output logic                                        busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]          state;
  logic [7:0]          beat_cnt;
  logic [IDW-1:0]      rr_ptr;

  logic                arb_go;
  logic                win_vld;
  logic [IDW-1:0]      win_id;
  logic [IDW-1:0]      cand;
  int                  scan;
  logic [NREQ-1:0]     win_onehot;
  logic [7:0]          beat_nxt;
  logic                burst_end;
  logic [DATASIZE-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*DATASIZE +: DATASIZE];
    end
  endgenerate

  assign busy      = (state == ST_BURST);
  assign req_ready = grant & {NREQ{busy & ~wfull}};
  assign winc      = |(req_valid & req_ready);
  assign wdata     = winc ? slice[grant_id] : '0;

  // Scan starts one past the last winner, so the previous owner has lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan    = 0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = (int'(rr_ptr) + k) % NREQ;
      cand = IDW'(scan);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
  assign arb_go     = win_vld && !((AF_STOP != 0) && almost_full);
  assign beat_nxt   = beat_cnt + 8'd1;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  // Grant is locked to the packet: bubbles and beat count never release it.
  assign burst_end = winc && req_last[grant_id];
`else
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);
  // A wfull stall is not a valid-low bubble, so release on valid-low only when not full.
  assign burst_end = (winc && (beat_nxt == MAX_B)) ||
                     (!wfull && !req_valid[grant_id]);
`endif

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= ST_ARB;
      grant    <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IDW'(NREQ - 1);
    end else begin
      case (state)
        ST_ARB: begin
          if (arb_go) begin
            grant    <= win_onehot;
            grant_id <= win_id;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (winc) begin
            beat_cnt <= beat_nxt;
          end
          if (burst_end) begin
            state  <= ST_ARB;
            grant  <= '0;
            rr_ptr <= grant_id;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  logic [3:0]  req_last;
`endif
  logic [3:0]  req_ready;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic        almost_full;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;

  int vectors;
  int miscompares;

  fifo_wr_arbiter #(
    .NREQ(4), .DATASIZE(8), .MAX_BURST(8), .AF_STOP(1)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .winc        (winc),
    .wdata       (wdata),
    .wfull       (wfull),
    .almost_full (almost_full),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Leaves the DUT in ARB with rr_ptr=3, at posedge+1.
  task automatic do_reset();
    wrst        = 1'b1;
    req_valid   = 4'b0000;
    wfull       = 1'b0;
    almost_full = 1'b0;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    req_last    = 4'b0000;
`endif
    tick();
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst        = 1'b1;
    req_valid   = 4'b1111;
    wfull       = 1'b0;
    almost_full = 1'b0;
    tick();
    tick();
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rst_grant got %b want %b", grant, 4'b0000); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    vectors++; if (winc !== 1'b0) begin miscompares++; $display("FAIL rst_winc got %b want 0", winc); end
    vectors++; if (wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata got %h want 00", wdata); end
    tick();
    wrst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_arb_cycle busy got %b want 0", busy); end
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL rst_first_grant got %b want 0001", grant); end
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rst_first_ready got %b want 0001", req_ready); end
    vectors++; if (wdata !== 8'hA0) begin miscompares++; $display("FAIL rst_first_wdata got %h want a0", wdata); end
    req_valid = 4'b0000;
    #1;
    vectors++; if (winc !== 1'b0) begin miscompares++; $display("FAIL rst_winc_novalid got %b want 0", winc); end
  endtask

  task automatic test_round_robin();
    int n_winc;
    int exp_id;
    logic exp_busy;
    do_reset();
    req_valid = 4'b1111;
    n_winc = 0;
    for (int c = 0; c < 36; c++) begin
      #1;
      exp_busy = ((c % 9) != 0);
      exp_id   = c / 9;
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL rr_busy c=%0d got %b want %b", c, busy, exp_busy); end
      vectors++; if (winc !== exp_busy) begin miscompares++; $display("FAIL rr_winc c=%0d got %b want %b", c, winc, exp_busy); end
      if (exp_busy) begin
        vectors++; if (grant !== (4'b0001 << exp_id)) begin miscompares++; $display("FAIL rr_grant c=%0d got %b want %b", c, grant, 4'b0001 << exp_id); end
        vectors++; if (grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rr_grant_id c=%0d got %0d want %0d", c, grant_id, exp_id); end
        vectors++; if (wdata !== (8'hA0 + 8'(exp_id * 17))) begin miscompares++; $display("FAIL rr_wdata c=%0d got %h want %h", c, wdata, 8'hA0 + 8'(exp_id * 17)); end
      end
      if (winc) n_winc++;
      tick();
    end
    #1;
    vectors++; if (n_winc !== 32) begin miscompares++; $display("FAIL rr_beats got %0d want 32", n_winc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_final_idle busy got %b want 0", busy); end
    req_valid = 4'b0000;
  endtask

  task automatic test_valid_drop();
    int n_winc;
    logic exp_x;
    do_reset();
    n_winc = 0;
    for (int c = 0; c <= 4; c++) begin
      req_valid = (c <= 3) ? 4'b0100 : 4'b0000;
      #1;
      exp_x = (c >= 1) && (c <= 3);
      vectors++; if (winc !== exp_x) begin miscompares++; $display("FAIL vd_winc c=%0d got %b want %b", c, winc, exp_x); end
      if (c >= 1) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL vd_busy c=%0d got %b want 1", c, busy); end
        vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL vd_grant c=%0d got %b want 0100", c, grant); end
      end
      if (winc) n_winc++;
      tick();
    end
    req_valid = 4'b0110;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL vd_release busy got %b want 0", busy); end
    vectors++; if (n_winc !== 3) begin miscompares++; $display("FAIL vd_beats got %0d want 3", n_winc); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL vd_next_grant got %b want 0010", grant); end
    repeat (8) tick();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL vd_gap busy got %b want 0", busy); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL vd_then_grant got %b want 0100", grant); end
    req_valid = 4'b0000;
  endtask

  task automatic test_full_stall();
    int n_winc;
    logic exp_x;
    do_reset();
    req_valid = 4'b0001;
    n_winc = 0;
    for (int c = 0; c <= 13; c++) begin
      wfull = (c >= 5) && (c <= 9);
      #1;
      exp_x = ((c >= 1) && (c <= 4)) || ((c >= 10) && (c <= 13));
      vectors++; if (winc !== exp_x) begin miscompares++; $display("FAIL fs_winc c=%0d got %b want %b", c, winc, exp_x); end
      vectors++; if (req_ready !== {3'b000, exp_x}) begin miscompares++; $display("FAIL fs_ready c=%0d got %b want %b", c, req_ready, {3'b000, exp_x}); end
      if (c >= 1) begin
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL fs_grant c=%0d got %b want 0001", c, grant); end
      end
      if (winc) n_winc++;
      tick();
    end
    wfull = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fs_end busy got %b want 0", busy); end
    vectors++; if (n_winc !== 8) begin miscompares++; $display("FAIL fs_beats got %0d want 8", n_winc); end
    req_valid = 4'b0000;
  endtask

  task automatic test_almost_full();
    do_reset();
    req_valid   = 4'b0010;
    almost_full = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      #1;
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL af_blocked c=%0d grant got %b want 0000", c, grant); end
      tick();
    end
    almost_full = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL af_arb busy got %b want 0", busy); end
    tick();
    almost_full = 1'b1;
    for (int c = 5; c <= 12; c++) begin
      #1;
      vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL af_burst_grant c=%0d got %b want 0010", c, grant); end
      vectors++; if (winc !== 1'b1) begin miscompares++; $display("FAIL af_burst_winc c=%0d got %b want 1", c, winc); end
      tick();
    end
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL af_burst_end busy got %b want 0", busy); end
    tick();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL af_regrant_blocked busy got %b want 0", busy); end
    almost_full = 1'b0;
    req_valid   = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c <= 3; c++) tick();
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmb_pre busy got %b want 1", busy); end
    wrst = 1'b1;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rmb_grant got %b want 0000", grant); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rmb_ready got %b want 0000", req_ready); end
    vectors++; if (winc !== 1'b0) begin miscompares++; $display("FAIL rmb_winc got %b want 0", winc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmb_busy got %b want 0", busy); end
    tick();
    tick();
    wrst = 1'b0;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rmb_release grant got %b want 0000", grant); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL rmb_regrant got %b want 0001", grant); end
    vectors++; if (wdata !== 8'hA0) begin miscompares++; $display("FAIL rmb_wdata got %h want a0", wdata); end
    req_valid = 4'b0000;
  endtask

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int n_winc;
    logic exp_x;
    do_reset();
    n_winc = 0;
    for (int c = 0; c <= 15; c++) begin
      req_valid = ((c <= 5) || ((c >= 8) && (c <= 14))) ? 4'b0010 : 4'b0000;
      req_last  = (c == 14) ? 4'b0010 : 4'b0000;
      #1;
      exp_x = ((c >= 1) && (c <= 5)) || ((c >= 8) && (c <= 14));
      vectors++; if (winc !== exp_x) begin miscompares++; $display("FAIL pl_winc c=%0d got %b want %b", c, winc, exp_x); end
      if ((c >= 1) && (c <= 14)) begin
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL pl_grant c=%0d got %b want 0010", c, grant); end
      end
      if (c == 15) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pl_release busy got %b want 0", busy); end
      end
      if (winc) n_winc++;
      tick();
    end
    vectors++; if (n_winc !== 12) begin miscompares++; $display("FAIL pl_beats got %0d want 12", n_winc); end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    req_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    req_last    = 4'b0000;
`endif
    test_reset();
    test_reset_mid_burst();
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    test_pkt_lock();
`else
    test_round_robin();
    test_valid_drop();
    test_full_stall();
    test_almost_full();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the asynchronous FIFO write domain. Shares a single FIFO write port (winc/wdata) among NREQ requesters using per-requester valid/ready handshakes. Grants bursts of up to MAX_BURST beats. Throttles on the FIFO's registered wfull and almost_full flags. Sits in the wclk domain directly in front of the FIFO's write-pointer/full logic.

Parameters:
NREQ, 4, number of requesters (2..8)
DATASIZE, 8, FIFO data width
MAX_BURST, 8, max beats per grant (1..255)
AF_STOP, 1, 1 = no new grant issued while almost_full is high

Ports:
wclk  input  1  write-domain clock
wrst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DATASIZE  packed data; requester i at [i*DATASIZE +: DATASIZE]
req_ready  output  NREQ  per-requester accept
winc  output  1  FIFO write enable
wdata  output  DATASIZE  FIFO write data
wfull  input  1  FIFO full flag (registered)
almost_full  input  1  FIFO almost-full flag (registered)
grant  output  NREQ  one-hot current grant, registered
grant_id  output  max(1,$clog2(NREQ))  index of granted requester
busy  output  1  high in BURST state

Behaviour:
- Reset (async on wrst high): state=ARB; grant=0; grant_id=0; busy=0; beat_cnt=0; rr_ptr=NREQ-1, so requester 0 wins first. Combinational outputs follow: req_ready=0, winc=0, wdata=0.
- A transfer is a cycle with req_valid[i] & req_ready[i].
- req_ready[i] = grant[i] & busy & ~wfull.
- winc = |(req_valid & req_ready).
- wdata = req_data slice of grant_id when winc=1, else 0.
- Only one requester is granted at a time, so winc never double-counts.
- ARB state:
  - Eligible when |req_valid and !(AF_STOP & almost_full).
  - Winner is the first set bit of req_valid scanning rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Register grant/grant_id, clear beat_cnt, go to BURST.
  - Latency: req_valid high in cycle N gives req_ready no earlier than cycle N+1.
- BURST state:
  - Each transfer increments beat_cnt (8-bit, saturating not required since bounded).
  - Burst ends and returns to ARB on the clock edge after:
    - (a) the transfer that makes beat_cnt reach MAX_BURST, or
    - (b) a cycle where req_valid[grant_id]=0 (no transfer that cycle).
  - On exit: grant=0, busy=0, rr_ptr=grant_id.
- wfull=1 during BURST: req_ready=0 and winc=0. The state holds and the burst is not released. beat_cnt is unchanged. The stall is not treated as valid-low.
- almost_full rising during BURST does not abort the burst. It only blocks the next ARB decision when AF_STOP=1.
- ARB occupies one cycle between bursts. Back-to-back bursts from different requesters are therefore separated by exactly one idle cycle.
- A requester that drops valid mid-burst loses the grant. It re-competes at its normal round-robin position.
- MAX_BURST=1: every grant carries one beat, giving strict per-beat round-robin with one idle cycle between beats.
- A single active requester is re-granted every burst. Throughput is MAX_BURST beats per MAX_BURST+1 cycles.

Optional Feature:
FIFO_WR_ARB_PKT_LOCK_EN
- Defined:
  - Adds input port req_last [NREQ].
  - A burst ends only after a transfer with req_last[grant_id]=1.
  - MAX_BURST and the valid-low release rule are disabled, so the grant holds across bubbles until packet end.
  - beat_cnt still counts, wrapping at 256.
- Not defined: req_last port absent; behaviour as above.

Test Plan:
- Reset mid-burst: assert wrst while busy=1 with beat_cnt=3 -> same cycle grant=0, req_ready=0, winc=0; after release with req_valid=4'b1111 -> grant=4'b0001 one cycle later.
- Round-robin fairness: all four valid continuously, MAX_BURST=8, FIFO never full -> grant sequence 0,1,2,3,0…; each burst exactly 8 winc pulses; one idle cycle between bursts; 32 beats in 36 cycles.
- Valid drop: requester 2 alone, drops valid after 3 beats -> busy falls next edge; beat count 3; with requesters 1 and 2 then valid, next grant goes to requester 3 if valid, else 0, 1, then 2.
- Full stall: force wfull=1 for 5 cycles mid-burst at beat 4 -> winc=0, req_ready=0 for those 5 cycles; grant held; burst resumes and completes beats 5..8.
- almost_full gating (AF_STOP=1): almost_full=1 with req_valid=4'b0010 in ARB -> no grant until almost_full=0; then grant=4'b0010 next cycle.
- With FIFO_WR_ARB_PKT_LOCK_EN: requester 1 sends 12-beat packet with a 2-cycle valid gap, req_last on beat 12 -> single uninterrupted grant; release only after beat 12.
